local_mem_weight_param: RTL and testbench

Parametrised local weight store for the convolution datapath. After reset it self-clears every word. It is then loaded by a handshaked burst of DATA_W-bit words from the DMA/bus side. It returns LANES consecutive words per registered read, which is one kernel row for the PE array. This block generalises the fixed 16-bit / 3-word weight store: it adds configurable depth and lane count, burst loading with an auto-incrementing address, a registered read with a valid flag, and error reporting.

---
 rtl/local_mem_weight_param.sv | 85 ++++++++
 tb/tb_local_mem_weight_param.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/local_mem_weight_param.sv
// local_mem_weight_param: self-clearing weight store with burst load and multi-lane registered read
module local_mem_weight_param #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8192,
  parameter int LANES  = 3,
  parameter int ADDR_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_start,
  input  logic [ADDR_W-1:0]         wr_base_addr,
  input  logic [ADDR_W-1:0]         wr_len,
  input  logic                      wr_valid,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      wr_ready,
  output logic                      wr_done,
  input  logic                      rd_req,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic                      rd_valid,
  output logic [LANES*DATA_W-1:0]   rd_data,
  output logic                      busy,
  output logic                      err
);
  localparam int MW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [MW-1:0] LAST = MW'(DEPTH - 1);
  typedef enum logic [1:0] {CLEAR, IDLE, LOAD, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [MW-1:0] clr_ptr, ptr, wa;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] wd;
  logic [LANES-1:0] in_range;
  logic [LANES*DATA_W-1:0] rd_next;
  logic len_ok, rd_ok, we;
  assign len_ok = wr_len != '0 && ({1'b0, wr_base_addr} + {1'b0, wr_len}) <= (ADDR_W+1)'(DEPTH);
  assign rd_ok = rd_req && (state == IDLE || state == DONE);
  assign wr_ready = state == LOAD;
  assign wr_done = state == DONE;
  assign busy = state != IDLE;
  assign we = state == CLEAR || (state == LOAD && wr_valid);
  assign wa = state == CLEAR ? clr_ptr : ptr;
  assign wd = state == CLEAR ? '0 : wr_data;
  // lane addresses carry two extra bits so groups near the top never wrap
  genvar k;
  for (k = 0; k < LANES; k++) begin : g_lane
    logic [ADDR_W+1:0] a;
    assign a = (ADDR_W+2)'(LANES) * {2'b00, rd_addr} + (ADDR_W+2)'(k);
    assign in_range[k] = a < (ADDR_W+2)'(DEPTH);
    assign rd_next[k*DATA_W +: DATA_W] = in_range[k] ? mem[a[MW-1:0]] : '0;
  end
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_ptr  <= '0;
      ptr      <= '0;
      cnt      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) rd_data <= rd_next;
      err <= (rd_ok && !(&in_range)) || (state == IDLE && wr_start && !len_ok);
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + MW'(1);
          if (clr_ptr == LAST) state <= IDLE;
        end
        IDLE: if (wr_start && len_ok) begin
          ptr   <= wr_base_addr[MW-1:0];
          cnt   <= wr_len;
          state <= LOAD;
        end
        LOAD: if (wr_valid) begin
          ptr <= ptr + MW'(1);
          cnt <= cnt - ADDR_W'(1);
          if (cnt == ADDR_W'(1)) state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_local_mem_weight_param.sv
// tb_local_mem_weight_param: table-driven and randomized checks against an array model of the store
module tb_local_mem_weight_param;
  localparam int DW = 16, DEPTH = 8192, LANES = 3, AW = 16;
  logic clk = 0, rst = 0, wr_start = 0, wr_valid = 0, rd_req = 0;
  logic [AW-1:0] wr_base_addr = '0, wr_len = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic wr_ready, wr_done, rd_valid, busy, err;
  logic [LANES*DW-1:0] rd_data;
  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] bq [$];
  typedef struct {int base; int len; logic e; logic b;} rej_t;
  typedef struct {int addr; logic [LANES*DW-1:0] data; logic e;} rd_t;
  rej_t rej [4] = '{'{8190, 4, 1'b1, 1'b0}, '{100, 0, 1'b1, 1'b0},
                    '{65535, 2, 1'b1, 1'b0}, '{8192, 1, 1'b1, 1'b0}};
  rd_t rtab [6] = '{'{0, 48'h0003_0002_0001, 1'b0}, '{65535, 48'h0, 1'b1},
                    '{1, 48'h0006_0005_0004, 1'b0}, '{2, 48'h0, 1'b0},
                    '{2729, 48'h0, 1'b0}, '{2730, 48'h0000_BBBB_AAAA, 1'b1}};

  always #5 clk = ~clk;

  local_mem_weight_param #(.DATA_W(DW), .DEPTH(DEPTH), .LANES(LANES), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .wr_start(wr_start), .wr_base_addr(wr_base_addr), .wr_len(wr_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .err(err));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [LANES*DW-1:0] exp_data(input int a);
    logic [LANES*DW-1:0] r = '0;
    for (int k = 0; k < LANES; k++)
      if (LANES * a + k < DEPTH) r[k*DW +: DW] = model[LANES * a + k];
    return r;
  endfunction

  function automatic logic exp_err(input int a);
    return LANES * a + LANES - 1 >= DEPTH;
  endfunction

  task automatic do_read(input int a, input string name);
    rd_req = 1; rd_addr = AW'(a);
    tick;
    rd_req = 0;
    chk({name, " valid"}, rd_valid, 1);
    chk({name, " data"}, rd_data, exp_data(a));
    chk({name, " err"}, err, exp_err(a));
  endtask

  task automatic reset_and_clear(input string name);
    int n = 0, bad = 0;
    rst = 1; wr_start = 0; wr_valid = 0; rd_req = 0;
    #2;
    chk({name, " rst busy"}, busy, 1);
    chk({name, " rst outputs"}, {wr_ready, wr_done, rd_valid, err}, 0);
    chk({name, " rst rd_data"}, rd_data, 0);
    tick; tick;
    rst = 0;
    foreach (model[i]) model[i] = '0;
    rd_req = 1; rd_addr = '1;
    while (busy && n < 20000) begin
      tick;
      n++;
      if (rd_valid || err || wr_done || wr_ready) bad++;
      if (!busy) rd_req = 0;
    end
    rd_req = 0;
    chk({name, " clear cycles"}, n, DEPTH);
    chk({name, " quiet during clear"}, bad, 0);
  endtask

  task automatic burst(input int base, input int len, input int gap_at, input int gap_n,
                       input bit rd_too, input string name);
    int cyc, nrdy = 0, bad = 0;
    wr_start = 1; wr_base_addr = AW'(base); wr_len = AW'(len);
    if (rd_too) begin rd_req = 1; rd_addr = '0; end
    tick;
    wr_start = 0; rd_req = 0; cyc = 1;
    if (rd_too) begin
      chk({name, " start+read valid"}, rd_valid, 1);
      chk({name, " start+read data"}, rd_data, exp_data(0));
    end
    for (int i = 0; i < len; i++) begin
      if (i == gap_at)
        for (int g = 0; g < gap_n; g++) begin
          wr_valid = 0; rd_req = 1; rd_addr = '0;
          tick;
          cyc++;
          if (rd_valid || err || wr_done) bad++;
        end
      rd_req = 0; wr_valid = 1; wr_data = bq[i];
      if (!wr_ready) nrdy++;
      tick;
      cyc++;
      model[base + i] = bq[i];
    end
    wr_valid = 0;
    while (!wr_done && cyc < len + gap_n + 20) begin
      tick;
      cyc++;
    end
    chk({name, " done latency"}, cyc, len + 1 + gap_n);
    chk({name, " ready held"}, nrdy, 0);
    if (gap_n > 0) chk({name, " read dropped in load"}, bad, 0);
    tick;
    chk({name, " done pulse width"}, wr_done, 0);
    chk({name, " idle after done"}, busy, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, len, a;
    tick;
    reset_and_clear("init");
    do_read(0, "post-clear");
    bq.delete();
    for (int i = 1; i <= 6; i++) bq.push_back(DW'(i));
    burst(0, 6, -1, 0, 0, "burst nogap");
    do_read(1, "nogap read");
    burst(0, 6, 3, 3, 1, "burst gap");
    do_read(1, "gap read");
    foreach (rej[i]) begin
      wr_start = 1; wr_base_addr = AW'(rej[i].base); wr_len = AW'(rej[i].len);
      tick;
      wr_start = 0;
      chk($sformatf("reject%0d err", i), err, rej[i].e);
      chk($sformatf("reject%0d busy", i), busy, rej[i].b);
      tick;
      chk($sformatf("reject%0d err pulse", i), err, 0);
    end
    bq.delete();
    bq.push_back(16'hAAAA);
    bq.push_back(16'hBBBB);
    burst(8190, 2, -1, 0, 0, "top burst");
    foreach (rtab[i]) begin
      rd_req = 1; rd_addr = AW'(rtab[i].addr);
      tick;
      chk($sformatf("table%0d valid", i), rd_valid, 1);
      chk($sformatf("table%0d data", i), rd_data, rtab[i].data);
      chk($sformatf("table%0d err", i), err, rtab[i].e);
    end
    rd_req = 0;
    tick;
    chk("hold valid", rd_valid, 0);
    chk("hold data", rd_data, rtab[5].data);
    for (int t = 0; t < 12; t++) begin
      base = (t % 4 == 0) ? DEPTH - $urandom_range(1, 8) : $urandom_range(0, DEPTH - 1);
      len = $urandom_range(1, (DEPTH - base < 8) ? DEPTH - base : 8);
      bq.delete();
      for (int i = 0; i < len; i++) bq.push_back(DW'($urandom));
      burst(base, len, $urandom_range(0, len - 1), $urandom_range(0, 3), t % 3 == 0, "rand burst");
      for (int r = 0; r < 3; r++) begin
        a = base / LANES + $urandom_range(0, 3) - 1;
        do_read(a < 0 ? 0 : a, "rand read");
      end
    end
    bq.delete();
    for (int i = 0; i < 5; i++) bq.push_back(DW'(16'h1234 + i));
    wr_start = 1; wr_base_addr = AW'(10); wr_len = AW'(5);
    tick;
    wr_start = 0;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1; wr_data = bq[i];
      tick;
    end
    wr_valid = 0;
    rst = 1;
    #2;
    chk("abort wr_done", wr_done, 0);
    chk("abort busy", busy, 1);
    reset_and_clear("abort");
    do_read(3, "abort read words 9-11");
    do_read(4, "abort read words 12-14");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
